// File: rtl/dot_operand_sequencer_if.sv
// Signal bundle between the operand sequencer, its upstream A/B stream,
// the FP dot-product unit and the downstream result consumer.
interface dot_operand_sequencer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] s_a_tdata;
   logic [DATA_W-1:0] s_b_tdata;
   logic              s_tvalid;
   logic              s_tready;

   logic [DATA_W-1:0] mul_A;
   logic [DATA_W-1:0] mul_B;
   logic              mul_valid;
   logic              mul_acc_sign;
   logic              mul_finish;
   logic              mul_sendable;
   logic [DATA_W-1:0] mul_result;

   logic [DATA_W-1:0] m_res_tdata;
   logic              m_res_tvalid;
   logic              m_res_tready;
   logic              m_res_tlast;

   modport master (
      input  s_a_tdata, s_b_tdata, s_tvalid,
      output s_tready,
      output mul_A, mul_B, mul_valid, mul_acc_sign, mul_finish,
      input  mul_sendable, mul_result,
      output m_res_tdata, m_res_tvalid, m_res_tlast,
      input  m_res_tready
   );

   modport slave (
      output s_a_tdata, s_b_tdata, s_tvalid,
      input  s_tready,
      input  mul_A, mul_B, mul_valid, mul_acc_sign, mul_finish,
      output mul_sendable, mul_result,
      input  m_res_tdata, m_res_tvalid, m_res_tlast,
      output m_res_tready
   );
endinterface

// File: rtl/dot_operand_sequencer.sv
// Splits a joint A/B operand stream into dot products of cfg_len pairs for the
// FP dot-product unit and returns each unit result on a valid/ready stream.
module dot_operand_sequencer #(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cfg_start,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic [LEN_W-1:0]        cfg_num_dots,
   dot_operand_sequencer_if.master bus,
   output logic                    busy,
   output logic                    err_cfg,
   output logic                    err_timeout
);

   localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_num_dots;
   logic [LEN_W-1:0]  r_elem_cnt;
   logic [LEN_W-1:0]  r_dot_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;

   logic [DATA_W-1:0] r_mul_a;
   logic [DATA_W-1:0] r_mul_b;
   logic              r_mul_valid;
   logic              r_mul_acc_sign;
   logic              r_mul_finish;
   logic [DATA_W-1:0] r_res_tdata;
   logic              r_res_tvalid;
   logic              r_res_tlast;
   logic              r_err_cfg;

   logic              w_cfg_ok;
   logic              w_s_tready;
   logic              w_s_hs;
   logic              w_last_pair;
   logic              w_last_dot;
   logic              w_res_hs;
   logic              w_timeout;

   // elem_cnt may reach len (one past the last index), so the compare below
   // never needs the counter to wrap even for len = 2^LEN_W-1.
   always_comb begin
      w_cfg_ok    = (cfg_len != '0) && (cfg_num_dots != '0);
      w_s_tready  = (r_state == S_FEED) && (r_elem_cnt < r_len);
      w_s_hs      = w_s_tready && bus.s_tvalid;
      w_last_pair = (r_elem_cnt == (r_len - LEN_W'(1)));
      w_last_dot  = (r_dot_cnt == (r_num_dots - LEN_W'(1)));
      w_res_hs    = (r_state == S_OUT) && bus.m_res_tready;
      w_timeout   = (r_state == S_DRAIN) && !bus.mul_sendable && (r_wait_cnt == WAIT_LAST);
   end

   always_ff @(posedge aclk) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default before the case, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (cfg_start && w_cfg_ok) w_state_nxt = S_FEED;
         S_FEED:  if (w_s_hs && w_last_pair) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            // A result arriving on the timeout cycle still wins.
            if (bus.mul_sendable) w_state_nxt = S_OUT;
            else if (w_timeout)   w_state_nxt = S_IDLE;
         end
         S_OUT:   if (w_res_hs) w_state_nxt = w_last_dot ? S_IDLE : S_FEED;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of the others regardless of order.
   // The synchronous reset also clears the data buses, not just control.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_len          <= '0;
         r_num_dots     <= '0;
         r_elem_cnt     <= '0;
         r_dot_cnt      <= '0;
         r_wait_cnt     <= '0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_mul_valid    <= 1'b0;
         r_mul_acc_sign <= 1'b0;
         r_mul_finish   <= 1'b0;
         r_res_tdata    <= '0;
         r_res_tvalid   <= 1'b0;
         r_res_tlast    <= 1'b0;
         r_err_cfg      <= 1'b0;
      end else begin
         r_err_cfg      <= (r_state == S_IDLE) && cfg_start && !w_cfg_ok;
         r_mul_valid    <= w_s_hs;
         r_mul_acc_sign <= w_s_hs && (r_elem_cnt != '0);
         r_mul_finish   <= w_s_hs && w_last_pair;
         if (w_s_hs) begin
            r_mul_a <= bus.s_a_tdata;
            r_mul_b <= bus.s_b_tdata;
         end

         case (r_state)
            S_IDLE: begin
               if (cfg_start && w_cfg_ok) begin
                  r_len      <= cfg_len;
                  r_num_dots <= cfg_num_dots;
                  r_elem_cnt <= '0;
                  r_dot_cnt  <= '0;
               end
            end
            S_FEED: begin
               if (w_s_hs) begin
                  r_elem_cnt <= r_elem_cnt + LEN_W'(1);
                  if (w_last_pair) r_wait_cnt <= '0;
               end
            end
            S_DRAIN: begin
               if (bus.mul_sendable) begin
                  r_res_tdata  <= bus.mul_result;
                  r_res_tvalid <= 1'b1;
                  r_res_tlast  <= w_last_dot;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            S_OUT: begin
               if (w_res_hs) begin
                  r_res_tvalid <= 1'b0;
                  r_res_tlast  <= 1'b0;
                  if (!w_last_dot) begin
                     r_dot_cnt  <= r_dot_cnt + LEN_W'(1);
                     r_elem_cnt <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.s_tready     = w_s_tready;
   assign bus.mul_A        = r_mul_a;
   assign bus.mul_B        = r_mul_b;
   assign bus.mul_valid    = r_mul_valid;
   assign bus.mul_acc_sign = r_mul_acc_sign;
   assign bus.mul_finish   = r_mul_finish;
   assign bus.m_res_tdata  = r_res_tdata;
   assign bus.m_res_tvalid = r_res_tvalid;
   assign bus.m_res_tlast  = r_res_tlast;
   assign busy             = (r_state != S_IDLE);
   assign err_cfg          = r_err_cfg;
   assign err_timeout      = w_timeout;

endmodule

// File: tb/tb_dot_operand_sequencer.sv
// Directed bench for dot_operand_sequencer: a scoreboard of expected unit
// operands and results, plus literal checks of pulse patterns and timing.
module tb_dot_operand_sequencer;

   localparam int DATA_W  = 32;
   localparam int LEN_W   = 16;
   localparam int TIMEOUT = 16;

   logic             aclk         = 1'b0;
   logic             areset       = 1'b1;
   logic             cfg_start    = 1'b0;
   logic [LEN_W-1:0] cfg_len      = '0;
   logic [LEN_W-1:0] cfg_num_dots = '0;
   logic             busy;
   logic             err_cfg;
   logic             err_timeout;

   dot_operand_sequencer_if #(.DATA_W(DATA_W)) bus ();

   dot_operand_sequencer #(
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .cfg_start    (cfg_start),
      .cfg_len      (cfg_len),
      .cfg_num_dots (cfg_num_dots),
      .bus          (bus),
      .busy         (busy),
      .err_cfg      (err_cfg),
      .err_timeout  (err_timeout)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        acc;
      logic        fin;
   } mul_exp_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } res_exp_t;

   mul_exp_t exp_mul [0:255];
   res_exp_t exp_res [0:255];
   int       mul_wr = 0;
   int       mul_rd = 0;
   int       res_wr = 0;
   int       res_rd = 0;

   logic     acc_log  [0:1023];
   logic     fin_log  [0:1023];
   logic     last_log [0:255];
   int       mul_cnt  = 0;
   int       res_cnt  = 0;

   int       n_checks = 0;
   int       n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired or unexpected event (t=%0t)", name, $time);
   endtask

   // Scoreboard: every unit pulse and every presented result is compared
   // against what the driver recorded from the stimulus it applied.
   always @(negedge aclk) begin
      if (areset) begin
         mul_rd = mul_wr;
         res_rd = res_wr;
      end else begin
         if (bus.mul_valid) begin
            if (mul_rd >= mul_wr) begin
               fail("mul_unexpected_pulse");
            end else begin
               check("mul_A",        bus.mul_A,        exp_mul[mul_rd].a);
               check("mul_B",        bus.mul_B,        exp_mul[mul_rd].b);
               check("mul_acc_sign", bus.mul_acc_sign, exp_mul[mul_rd].acc);
               check("mul_finish",   bus.mul_finish,   exp_mul[mul_rd].fin);
               mul_rd++;
            end
            acc_log[mul_cnt] = bus.mul_acc_sign;
            fin_log[mul_cnt] = bus.mul_finish;
            mul_cnt++;
         end else begin
            check("mul_flags_idle", {bus.mul_acc_sign, bus.mul_finish}, 2'b00);
         end

         if (bus.m_res_tvalid) begin
            if (res_rd >= res_wr) begin
               fail("res_unexpected_valid");
            end else begin
               check("res_tdata", bus.m_res_tdata, exp_res[res_rd].data);
               check("res_tlast", bus.m_res_tlast, exp_res[res_rd].last);
               if (bus.m_res_tready) begin
                  last_log[res_cnt] = bus.m_res_tlast;
                  res_cnt++;
                  res_rd++;
               end
            end
         end
      end
   end

   function automatic logic [7:0] log_bits(input int which, input int base, input int n);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < n; i++) begin
         case (which)
            0:       v[i] = acc_log[base + i];
            1:       v[i] = fin_log[base + i];
            default: v[i] = last_log[base + i];
         endcase
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic start_job(input int len, input int dots);
      cfg_len      = LEN_W'(len);
      cfg_num_dots = LEN_W'(dots);
      cfg_start    = 1'b1;
      tick();
      cfg_start    = 1'b0;
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int k, input int len);
      int cyc;
      cyc           = 0;
      bus.s_a_tdata = a;
      bus.s_b_tdata = b;
      bus.s_tvalid  = 1'b1;
      @(negedge aclk);
      while (!bus.s_tready && cyc < 50) begin
         cyc++;
         @(negedge aclk);
      end
      if (!bus.s_tready) begin
         fail("s_tready_wait");
      end else begin
         exp_mul[mul_wr] = '{a: a, b: b, acc: (k != 0), fin: (k == len - 1)};
         mul_wr++;
      end
      @(posedge aclk);
      #1;
      bus.s_tvalid = 1'b0;
   endtask

   task automatic unit_result(input int wait_cyc, input logic [31:0] r, input logic last);
      repeat (wait_cyc) tick();
      exp_res[res_wr] = '{data: r, last: last};
      res_wr++;
      bus.mul_result   = r;
      bus.mul_sendable = 1'b1;
      tick();
      bus.mul_sendable = 1'b0;
   endtask

   task automatic take_result(input int stall);
      int cyc;
      cyc              = 0;
      bus.m_res_tready = 1'b0;
      while (!bus.m_res_tvalid && cyc < 100) begin
         tick();
         cyc++;
      end
      if (!bus.m_res_tvalid) begin
         fail("res_tvalid_wait");
      end else begin
         repeat (stall) tick();
         bus.m_res_tready = 1'b1;
         tick();
         bus.m_res_tready = 1'b0;
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"},        busy,             1'b0);
      check({tag, "_err_cfg"},     err_cfg,          1'b0);
      check({tag, "_err_timeout"}, err_timeout,      1'b0);
      check({tag, "_s_tready"},    bus.s_tready,     1'b0);
      check({tag, "_mul_valid"},   bus.mul_valid,    1'b0);
      check({tag, "_mul_acc"},     bus.mul_acc_sign, 1'b0);
      check({tag, "_mul_finish"},  bus.mul_finish,   1'b0);
      check({tag, "_mul_A"},       bus.mul_A,        32'h0);
      check({tag, "_mul_B"},       bus.mul_B,        32'h0);
      check({tag, "_res_tdata"},   bus.m_res_tdata,  32'h0);
      check({tag, "_res_tvalid"},  bus.m_res_tvalid, 1'b0);
      check({tag, "_res_tlast"},   bus.m_res_tlast,  1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bm;
      int br;
      int first_to;
      int to_pulses;
      int seen_valid;

      bus.s_a_tdata    = '0;
      bus.s_b_tdata    = '0;
      bus.s_tvalid     = 1'b0;
      bus.mul_sendable = 1'b0;
      bus.mul_result   = '0;
      bus.m_res_tready = 1'b0;

      // Reset state
      repeat (3) tick();
      @(negedge aclk);
      check_quiet("reset");
      areset = 1'b0;
      tick();

      // 1: len=4, one dot of 1.0*2.0, result after 10 cycles
      bm = mul_cnt;
      br = res_cnt;
      start_job(4, 1);
      check("t1_busy", busy, 1'b1);
      for (int k = 0; k < 4; k++) send_pair(32'h3F80_0000, 32'h4000_0000, k, 4);
      check("t1_s_tready_drain", bus.s_tready, 1'b0);
      unit_result(10, 32'h4100_0000, 1'b1);
      take_result(0);
      tick();
      check("t1_pulses",  mul_cnt - bm, 4);
      check("t1_acc_seq", log_bits(0, bm, 4), 8'b0000_1110);
      check("t1_fin_seq", log_bits(1, bm, 4), 8'b0000_1000);
      check("t1_results", res_cnt - br, 1);
      check("t1_tlast",   log_bits(2, br, 1), 8'b0000_0001);
      check("t1_idle",    busy, 1'b0);

      // 2: len=1, three dots, consumer stalls 5 cycles on the second result
      bm = mul_cnt;
      br = res_cnt;
      start_job(1, 3);
      for (int d = 0; d < 3; d++) begin
         send_pair(32'h4000_0000 + 32'(d), 32'h3F00_0000 + 32'(d), 0, 1);
         case (d)
            0:       unit_result(3, 32'h3F80_0000, 1'b0);
            1:       unit_result(3, 32'h4040_0000, 1'b0);
            default: unit_result(3, 32'hC0A0_0000, 1'b1);
         endcase
         take_result((d == 1) ? 5 : 0);
      end
      tick();
      check("t2_pulses",   mul_cnt - bm, 3);
      check("t2_acc_seq",  log_bits(0, bm, 3), 8'b0000_0000);
      check("t2_fin_seq",  log_bits(1, bm, 3), 8'b0000_0111);
      check("t2_results",  res_cnt - br, 3);
      check("t2_tlast_seq", log_bits(2, br, 3), 8'b0000_0100);
      check("t2_idle",     busy, 1'b0);

      // 3: zero length, then zero dot count
      start_job(0, 2);
      check("t3a_err_cfg",  err_cfg, 1'b1);
      check("t3a_busy",     busy, 1'b0);
      check("t3a_s_tready", bus.s_tready, 1'b0);
      tick();
      check("t3a_err_cfg_pulse", err_cfg, 1'b0);
      start_job(3, 0);
      check("t3b_err_cfg",  err_cfg, 1'b1);
      check("t3b_busy",     busy, 1'b0);
      check("t3b_s_tready", bus.s_tready, 1'b0);
      tick();
      check("t3b_err_cfg_pulse", err_cfg, 1'b0);

      // 4: no sendable -> timeout on DRAIN cycle TIMEOUT-1, no result
      start_job(2, 1);
      send_pair(32'h1111_1111, 32'h2222_2222, 0, 2);
      send_pair(32'h3333_3333, 32'h4444_4444, 1, 2);
      first_to   = -1;
      to_pulses  = 0;
      seen_valid = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         if (err_timeout) begin
            to_pulses++;
            if (first_to < 0) first_to = c;
         end
         if (bus.m_res_tvalid) seen_valid = 1;
         if (c == 16) check("t4_idle_after_timeout", busy, 1'b0);
      end
      check("t4_timeout_cycle",  first_to, 15);
      check("t4_timeout_pulses", to_pulses, 1);
      check("t4_no_result",      seen_valid, 0);
      tick();

      // 4b: sendable on the timeout cycle wins
      br = res_cnt;
      start_job(1, 1);
      send_pair(32'h5555_5555, 32'h6666_6666, 0, 1);
      repeat (15) tick();
      exp_res[res_wr] = '{data: 32'h4248_0000, last: 1'b1};
      res_wr++;
      bus.mul_result   = 32'h4248_0000;
      bus.mul_sendable = 1'b1;
      @(negedge aclk);
      check("t4b_no_timeout", err_timeout, 1'b0);
      tick();
      bus.mul_sendable = 1'b0;
      take_result(0);
      tick();
      check("t4b_results", res_cnt - br, 1);

      // 5: reset after 2 of 4 pairs, then a clean job
      start_job(4, 1);
      send_pair(32'h7777_7777, 32'h8888_8888, 0, 4);
      send_pair(32'h9999_9999, 32'hAAAA_AAAA, 1, 4);
      bus.s_a_tdata = 32'hBBBB_BBBB;
      bus.s_b_tdata = 32'hCCCC_CCCC;
      bus.s_tvalid  = 1'b1;
      areset        = 1'b1;
      tick();
      areset        = 1'b0;
      bus.s_tvalid  = 1'b0;
      @(negedge aclk);
      check_quiet("t5_after_reset");
      tick();
      bm = mul_cnt;
      br = res_cnt;
      start_job(2, 1);
      send_pair(32'h4000_0000, 32'h4040_0000, 0, 2);
      send_pair(32'h3F80_0000, 32'h3F80_0000, 1, 2);
      unit_result(4, 32'h40E0_0000, 1'b1);
      take_result(0);
      tick();
      check("t5_pulses",  mul_cnt - bm, 2);
      check("t5_acc_seq", log_bits(0, bm, 2), 8'b0000_0010);
      check("t5_fin_seq", log_bits(1, bm, 2), 8'b0000_0010);
      check("t5_results", res_cnt - br, 1);

      // 6: s_tvalid toggling with len=3; cfg_start during gaps is ignored
      bm = mul_cnt;
      br = res_cnt;
      start_job(3, 1);
      for (int k = 0; k < 3; k++) begin
         send_pair(32'h4100_0000 + 32'(k), 32'h4200_0000 + 32'(k), k, 3);
         @(negedge aclk);
         check("t6_pulse", bus.mul_valid, 1'b1);
         if (k < 2) begin
            cfg_start    = 1'b1;
            cfg_len      = (k == 0) ? LEN_W'(0) : LEN_W'(5);
            cfg_num_dots = (k == 0) ? LEN_W'(1) : LEN_W'(5);
            tick();
            cfg_start = 1'b0;
            check("t6_gap",          bus.mul_valid, 1'b0);
            check("t6_no_err_cfg",   err_cfg, 1'b0);
         end else begin
            tick();
         end
      end
      unit_result(2, 32'h4040_0000, 1'b1);
      take_result(0);
      tick();
      check("t6_pulses",  mul_cnt - bm, 3);
      check("t6_acc_seq", log_bits(0, bm, 3), 8'b0000_0110);
      check("t6_fin_seq", log_bits(1, bm, 3), 8'b0000_0100);
      check("t6_tlast",   log_bits(2, br, 1), 8'b0000_0001);
      check("t6_idle",    busy, 1'b0);

      tick();
      check("mul_queue_drained", mul_wr - mul_rd, 0);
      check("res_queue_drained", res_wr - res_rd, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
